// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 keyboard receiver: frame FSM states, prefix bytes
// and the key event record queued for the consumer.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

endpackage

// File: rtl/ps2_key_fifo.sv
// Key event FIFO: valid/ready pop at the head, push that drops and flags
// overflow when full unless a pop frees a slot in the same cycle.
module ps2_key_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  key_event_t push_ev,
    output logic       overflow,
    output logic       valid,
    input  logic       ready,
    output key_event_t head
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = FIFO_DEPTH[AW:0];

    key_event_t      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, pop, push_ok;

    assign full     = (count == DEPTH_C);
    assign valid    = (count != '0);
    assign pop      = valid & ready;
    assign push_ok  = push & (~full | pop);
    assign overflow = push & full & ~pop;
    // Head is forced to zero when empty so outputs are clean during reset.
    assign head     = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_ev;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deframes bytes, folds
// E0/F0 prefixes into flags and queues {ext, brk, code} events.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_s, data_s, clk_q, fall;

    ps2_state_e  state, state_n;
    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic        par_bit;
    logic [TW-1:0] to_cnt;
    logic        ext_f, brk_f;
    logic        timeout, byte_done, par_bad, stop_bad;
    logic        push;
    key_event_t  push_ev, head;

    // Synchronisers idle high so reset never manufactures a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_q     <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_q     <= clk_s;
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_q & ~clk_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        timeout   = 1'b0;
        byte_done = 1'b0;
        par_bad   = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE:   if (fall && !data_s) state_n = DATA;
            DATA:   if (fall && bit_cnt == 3'd7) state_n = PARITY;
            PARITY: if (fall) state_n = STOP;
            STOP: begin
                if (fall) begin
                    state_n = IDLE;
                    if (!data_s)
                        stop_bad = 1'b1;
                    else if (!(^{shift, par_bit}))
                        par_bad = 1'b1;
                    else
                        byte_done = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (state != IDLE && !fall && to_cnt == TO_LAST) begin
            state_n = IDLE;
            timeout = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift      <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            ext_f      <= 1'b0;
            brk_f      <= 1'b0;
            push       <= 1'b0;
            push_ev    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            push       <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (state == IDLE || fall) to_cnt <= '0;
            else                       to_cnt <= to_cnt + 1'b1;

            if (state == IDLE) bit_cnt <= '0;
            if (fall && state == DATA) begin
                shift   <= {data_s, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (fall && state == PARITY) par_bit <= data_s;

            if (timeout || stop_bad) begin
                frame_err <= 1'b1;
                ext_f     <= 1'b0;
                brk_f     <= 1'b0;
            end else if (par_bad) begin
                parity_err <= 1'b1;
                ext_f      <= 1'b0;
                brk_f      <= 1'b0;
            end else if (byte_done) begin
                // Prefix bytes only arm flags; the next real code carries them.
                if (shift == PS2_EXT_PREFIX)
                    ext_f <= 1'b1;
                else if (shift == PS2_BREAK_PREFIX)
                    brk_f <= 1'b1;
                else begin
                    push    <= 1'b1;
                    push_ev <= '{ext: ext_f, brk: brk_f, code: shift};
                    ext_f   <= 1'b0;
                    brk_f   <= 1'b0;
                end
            end
        end
    end

    ps2_key_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_ev  (push_ev),
        .overflow (overflow),
        .valid    (key_valid),
        .ready    (key_ready),
        .head     (head)
    );

    assign key_code  = head.code;
    assign key_break = head.brk;
    assign key_ext   = head.ext;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: bit-bangs PS/2 frames and checks the
// decoded event stream, error pulses, FIFO back-pressure and reset behaviour.
module tb_ps2_key_receiver;

    localparam int FD   = 8;
    localparam int SS   = 2;
    localparam int TO   = 300;
    localparam int HALF = 20;

    logic       clk = 1'b0, reset = 1'b0;
    logic       ps2_clk = 1'b1, ps2_data = 1'b1, key_ready = 1'b1;
    logic [7:0] key_code;
    logic       key_break, key_ext, key_valid, parity_err, frame_err, overflow;

    int tests = 0, fails = 0;
    int n_par = 0, n_frm = 0, n_ovf = 0;
    int p0, f0, o0;
    logic [9:0] evq [$];
    logic [7:0] codes [9] = '{8'h15, 8'h16, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43};

    ps2_key_receiver #(.FIFO_DEPTH(FD), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_code   (key_code),
        .key_break  (key_break),
        .key_ext    (key_ext),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Record every accepted event and count error pulses.
    always @(negedge clk) begin
        if (reset && key_valid && key_ready) evq.push_back({key_ext, key_break, key_code});
        if (parity_err) n_par++;
        if (frame_err)  n_frm++;
        if (overflow)   n_ovf++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_ev(input string tag, input logic [9:0] exp);
        logic [9:0] ev;
        ev = (evq.size() > 0) ? evq.pop_front() : 10'bx;
        chk(tag, {22'd0, ev}, {22'd0, exp});
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par = 1'b0, input bit stop = 1'b1,
                        input int nbits = 11, input bit chk_lat = 1'b0);
        logic [10:0] fr;
        fr = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            cyc(HALF / 2);
            ps2_clk = 1'b0;
            if (chk_lat && i == 10) begin
                cyc(3);
                chk("lat_lo", {31'd0, key_valid}, 32'd0);
                cyc(1);
                chk("lat_hi", {31'd0, key_valid}, 32'd1);
                cyc(HALF - 4);
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b1;
            cyc(HALF / 2);
        end
        ps2_data = 1'b1;
        cyc(2 * HALF);
    endtask

    initial begin
        cyc(3);
        chk("rst_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_outs", {18'd0, key_code, key_break, key_ext, parity_err, frame_err, overflow}, 32'd0);
        reset = 1'b1;
        cyc(5);

        send(8'h1C, 1'b0, 1'b1, 11, 1'b1);
        chk("n_1c", evq.size(), 1);
        chk_ev("ev_1c", {2'b00, 8'h1C});

        send(8'hF0); send(8'h1C);
        chk("n_brk", evq.size(), 1);
        chk_ev("ev_brk", {2'b01, 8'h1C});

        send(8'hE0); send(8'hF0); send(8'h75);
        chk("n_extbrk", evq.size(), 1);
        chk_ev("ev_extbrk", {2'b11, 8'h75});

        // Bad parity after E0 also discards the pending prefix.
        p0 = n_par;
        send(8'hE0); send(8'h1B, 1'b1);
        chk("par_pulse", n_par - p0, 1);
        chk("par_noev", evq.size(), 0);
        send(8'h23);
        chk_ev("ev_23", {2'b00, 8'h23});

        f0 = n_frm;
        send(8'hE0); send(8'h1C, 1'b0, 1'b0);
        chk("stop_pulse", n_frm - f0, 1);
        chk("stop_noev", evq.size(), 0);
        send(8'h24);
        chk_ev("ev_24", {2'b00, 8'h24});

        key_ready = 1'b0;
        o0 = n_ovf;
        for (int i = 0; i < 8; i++) send(codes[i]);
        chk("ovf_none", n_ovf - o0, 0);
        send(codes[8]);
        chk("ovf_pulse", n_ovf - o0, 1);
        chk("full_valid", {31'd0, key_valid}, 32'd1);
        chk("head_code", {24'd0, key_code}, {24'd0, codes[0]});
        cyc(20);
        chk("head_hold", {22'd0, key_ext, key_break, key_code}, {22'd0, 2'b00, codes[0]});
        key_ready = 1'b1;
        cyc(12);
        chk("drain_n", evq.size(), 8);
        for (int i = 0; i < 8; i++) chk_ev("ev_drain", {2'b00, codes[i]});
        chk("drain_empty", {31'd0, key_valid}, 32'd0);

        f0 = n_frm;
        send(8'h1C, 1'b0, 1'b1, 6);
        chk("to_early", n_frm - f0, 0);
        cyc(TO + 10);
        chk("to_pulse", n_frm - f0, 1);
        send(8'h1C);
        chk_ev("ev_after_to", {2'b00, 8'h1C});

        // Leave an event queued, then reset during a frame that follows E0.
        key_ready = 1'b0;
        send(8'h1C);
        send(8'hE0);
        send(8'h74, 1'b0, 1'b1, 4);
        chk("pre_rst_valid", {31'd0, key_valid}, 32'd1);
        reset = 1'b0;
        cyc(2);
        chk("midrst_outs", {17'd0, key_valid, key_code, key_break, key_ext, parity_err, frame_err, overflow},
            32'd0);
        reset = 1'b1;
        key_ready = 1'b1;
        cyc(5);
        send(8'h74);
        chk("n_after_rst", evq.size(), 1);
        chk_ev("ev_after_rst", {2'b00, 8'h74});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops on ps2_clk/ps2_data (>=2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 5000, clk cycles allowed between ps2_clk falling edges mid-frame.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous.
REQ-007 ps2_data  input  1  raw PS/2 data from keyboard, asynchronous.
REQ-008 key_code  output  8  scan code of head FIFO event.
REQ-009 key_break  output  1  head event is a release (preceded by F0).
REQ-010 key_ext  output  1  head event is extended (preceded by E0).
REQ-011 key_valid  output  1  FIFO non-empty; head event valid.
REQ-012 key_ready  input  1  consumer accepts head event.
REQ-013 parity_err  output  1  one-cycle pulse, byte dropped on bad parity.
REQ-014 frame_err  output  1  one-cycle pulse, bad stop bit or timeout.
REQ-015 overflow  output  1  one-cycle pulse, event dropped because FIFO full.

Function
REQ-016 ps2_clk/ps2_data SHALL pass through SYNC_STAGES flops; a falling edge is synced ps2_clk 1 -> 0 between consecutive clk cycles.
REQ-017 Frame: start(0), 8 data LSB first, odd parity, stop(1); each bit sampled from synced ps2_data on a detected falling edge.
REQ-018 FSM states IDLE, DATA, PARITY, STOP; IDLE->DATA on edge with data=0 (data=1 ignored, stays IDLE); DATA->PARITY after 8th bit; PARITY->STOP on next edge; STOP->IDLE on next edge.
REQ-019 Bad parity SHALL drop the byte, pulse parity_err, clear prefix flags.
REQ-020 Stop bit 0 SHALL drop the byte, pulse frame_err, clear prefix flags.
REQ-021 In DATA/PARITY/STOP, TIMEOUT_CYCLES cycles without a falling edge SHALL return to IDLE, pulse frame_err, clear prefix flags.
REQ-022 Valid byte 8'hE0 SHALL set ext flag; 8'hF0 SHALL set break flag; neither pushes an event.
REQ-023 Any other valid byte SHALL push {ext, break, byte} and clear both flags.
REQ-024 Event push latency: key_valid high exactly 2 clk cycles after the cycle the stop-bit edge is detected (empty FIFO).
REQ-025 Pop SHALL occur on cycle with key_valid & key_ready; key_ready with key_valid low is ignored.
REQ-026 Push while full without same-cycle pop SHALL drop the event and pulse overflow; full with simultaneous pop SHALL accept the push.
REQ-027 Simultaneous push and pop on non-empty FIFO SHALL keep count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-028 key_code/key_break/key_ext SHALL hold while key_valid high and not popped.

Reset
REQ-029 reset low SHALL immediately force FSM IDLE, flags, bit counter, timeout counter, FIFO pointers/count to 0, synchronisers to 1.
REQ-030 Outputs during reset: key_valid, key_code, key_break, key_ext, parity_err, frame_err, overflow all 0.
REQ-031 Reset mid-frame SHALL discard the partial byte; first falling edge after release with data=0 starts a new frame.

Structure
REQ-032 Package ps2_pkg SHALL hold FSM state enum, PS2_EXT_PREFIX=8'hE0, PS2_BREAK_PREFIX=8'hF0, key event struct {ext, brk, code[7:0]}.
REQ-033 Event FIFO SHALL be sub-module ps2_key_fifo (parameter FIFO_DEPTH, valid/ready pop, push-with-overflow).

Verification
REQ-034 Frame 0x1C, odd parity ok, key_ready=1 -> one event code=0x1C, break=0, ext=0, key_valid 2 cycles after stop edge.
REQ-035 Bytes F0,1C -> single event code=0x1C, break=1; E0,F0,75 -> code=0x75, ext=1, break=1.
REQ-036 0x1B with parity bit flipped -> parity_err pulse, no event; following 0x23 -> event with flags 0.
REQ-037 key_ready=0, send 9 make codes with FIFO_DEPTH=8 -> 8 events held, overflow pulse on 9th; then drain in order, key_valid low after 8 pops.
REQ-038 Stop after 5 data bits, wait TIMEOUT_CYCLES+1 -> frame_err pulse, FSM IDLE; next full 0x1C frame decoded correctly.
REQ-039 Assert reset mid-frame after E0 received -> outputs 0; next 0x74 -> event ext=0.
